// File: rtl/seg_scan_decoder.sv
// Two-digit multiplexed 7-segment scan decoder with frame debounce.
// Optional macro HEX_DECODE_EN adds the A-F glyphs to the code table.
//
// Ports:
//   clk        : rising-edge clock
//   nRST       : asynchronous active-low reset
//   nEN        : active-low block enable (synchronous)
//   seg_in     : sampled segment bus {g,f,e,d,c,b,a}, active-high
//   digit_sel  : 0 = digit A on seg_in, 1 = digit B
//   seg_strobe : one-cycle qualifier for seg_in/digit_sel
//   A_out      : last committed value of digit A
//   B_out      : last committed value of digit B
//   valid      : one-cycle pulse when A_out/B_out update
//   err        : one-cycle pulse on illegal frame or out-of-order strobe
module seg_scan_decoder #(
    parameter int STABLE_FRAMES = 2
) (
    input  logic       clk,
    input  logic       nRST,
    input  logic       nEN,
    input  logic [6:0] seg_in,
    input  logic       digit_sel,
    input  logic       seg_strobe,
    output logic [3:0] A_out,
    output logic [3:0] B_out,
    output logic       valid,
    output logic       err
);

    if (STABLE_FRAMES < 1 || STABLE_FRAMES > 15) begin : g_bad_param
        $error("STABLE_FRAMES must be in 1..15");
    end

    localparam logic [3:0] SAT = 4'(STABLE_FRAMES - 1);

    typedef enum logic [1:0] {
        SCAN_A = 2'd0,
        SCAN_B = 2'd1,
        COMMIT = 2'd2
    } state_e;

    // Returns {legal, value}; value is 0 when illegal.
    function automatic logic [4:0] decode(input logic [6:0] s);
        logic [4:0] r;
        case (s)
            7'h3F:   r = {1'b1, 4'h0};
            7'h06:   r = {1'b1, 4'h1};
            7'h5B:   r = {1'b1, 4'h2};
            7'h4F:   r = {1'b1, 4'h3};
            7'h66:   r = {1'b1, 4'h4};
            7'h6D:   r = {1'b1, 4'h5};
            7'h7D:   r = {1'b1, 4'h6};
            7'h07:   r = {1'b1, 4'h7};
            7'h7F:   r = {1'b1, 4'h8};
            7'h6F:   r = {1'b1, 4'h9};
`ifdef HEX_DECODE_EN
            7'h77:   r = {1'b1, 4'hA};
            7'h7C:   r = {1'b1, 4'hB};
            7'h39:   r = {1'b1, 4'hC};
            7'h5E:   r = {1'b1, 4'hD};
            7'h79:   r = {1'b1, 4'hE};
            7'h71:   r = {1'b1, 4'hF};
`endif
            default: r = 5'd0;
        endcase
        return r;
    endfunction

    state_e     state_q,    state_d;
    logic [4:0] cand_a_q,   cand_a_d;
    logic [4:0] cand_b_q,   cand_b_d;
    logic       prev_vld_q, prev_vld_d;
    logic [3:0] prev_a_q,   prev_a_d;
    logic [3:0] prev_b_q,   prev_b_d;
    logic [3:0] stab_q,     stab_d;
    logic [3:0] a_out_q,    a_out_d;
    logic [3:0] b_out_q,    b_out_d;
    logic       valid_q,    valid_d;
    logic       err_q,      err_d;

    logic [4:0] dec;
    logic       legal;
    logic       same;
    logic       load;

    assign dec   = decode(seg_in);
    assign legal = cand_a_q[4] & cand_b_q[4];
    assign same  = prev_vld_q
                 && (prev_a_q == cand_a_q[3:0])
                 && (prev_b_q == cand_b_q[3:0]);

    always_comb begin
        state_d    = state_q;
        cand_a_d   = cand_a_q;
        cand_b_d   = cand_b_q;
        prev_vld_d = prev_vld_q;
        prev_a_d   = prev_a_q;
        prev_b_d   = prev_b_q;
        stab_d     = stab_q;
        a_out_d    = a_out_q;
        b_out_d    = b_out_q;
        valid_d    = 1'b0;
        err_d      = 1'b0;
        load       = 1'b0;

        if (nEN) begin
            state_d    = SCAN_A;
            stab_d     = 4'd0;
            prev_vld_d = 1'b0;
        end else begin
            case (state_q)
                SCAN_A: begin
                    if (seg_strobe) begin
                        if (!digit_sel) begin
                            cand_a_d = dec;
                            state_d  = SCAN_B;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                SCAN_B: begin
                    if (seg_strobe) begin
                        if (digit_sel) begin
                            cand_b_d = dec;
                            state_d  = COMMIT;
                        end else begin
                            // resync to the newest A digit
                            cand_a_d = dec;
                            err_d    = 1'b1;
                        end
                    end
                end
                COMMIT: begin
                    state_d = SCAN_A;
                    if (!legal) begin
                        err_d      = 1'b1;
                        stab_d     = 4'd0;
                        prev_vld_d = 1'b0;
                    end else if (same) begin
                        if (stab_q != SAT) begin
                            stab_d = stab_q + 4'd1;
                        end
                        // update only on the step that reaches SAT;
                        // with SAT==0 every legal frame updates
                        load = (SAT == 4'd0)
                            || ((stab_q != SAT)
                            && ((stab_q + 4'd1) == SAT));
                    end else begin
                        stab_d     = 4'd0;
                        prev_vld_d = 1'b1;
                        prev_a_d   = cand_a_q[3:0];
                        prev_b_d   = cand_b_q[3:0];
                        load       = (SAT == 4'd0);
                    end
                    if (load) begin
                        a_out_d = cand_a_q[3:0];
                        b_out_d = cand_b_q[3:0];
                        valid_d = 1'b1;
                    end
                end
                default: state_d = SCAN_A;
            endcase
        end
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state_q    <= SCAN_A;
            cand_a_q   <= 5'd0;
            cand_b_q   <= 5'd0;
            prev_vld_q <= 1'b0;
            prev_a_q   <= 4'd0;
            prev_b_q   <= 4'd0;
            stab_q     <= 4'd0;
            a_out_q    <= 4'd0;
            b_out_q    <= 4'd0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cand_a_q   <= cand_a_d;
            cand_b_q   <= cand_b_d;
            prev_vld_q <= prev_vld_d;
            prev_a_q   <= prev_a_d;
            prev_b_q   <= prev_b_d;
            stab_q     <= stab_d;
            a_out_q    <= a_out_d;
            b_out_q    <= b_out_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
        end
    end

    assign A_out = a_out_q;
    assign B_out = b_out_q;
    assign valid = valid_q;
    assign err   = err_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed self-checking bench for seg_scan_decoder (STABLE_FRAMES=2).
// Expected values are hand-computed from the code table.
module tb_seg_scan_decoder;

    logic       clk = 1'b0;
    logic       nRST = 1'b0;
    logic       nEN = 1'b0;
    logic [6:0] seg_in = 7'h00;
    logic       digit_sel = 1'b0;
    logic       seg_strobe = 1'b0;
    logic [3:0] A_out;
    logic [3:0] B_out;
    logic       valid;
    logic       err;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    seg_scan_decoder #(.STABLE_FRAMES(2)) dut (
        .clk        (clk),
        .nRST       (nRST),
        .nEN        (nEN),
        .seg_in     (seg_in),
        .digit_sel  (digit_sel),
        .seg_strobe (seg_strobe),
        .A_out      (A_out),
        .B_out      (B_out),
        .valid      (valid),
        .err        (err)
    );

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One strobe; returns at the negedge after the sampling posedge.
    task automatic send(input logic sel, input logic [6:0] pat);
        @(negedge clk);
        seg_strobe = 1'b1;
        digit_sel  = sel;
        seg_in     = pat;
        @(negedge clk);
        seg_strobe = 1'b0;
    endtask

    // Full A/B frame, then check the commit result one cycle later.
    // cs=1 drives a B-type strobe during the COMMIT cycle.
    task automatic frame(input string tag,
                         input logic [6:0] a, input logic [6:0] b,
                         input logic ev, input logic ee,
                         input logic [3:0] ea, input logic [3:0] eb,
                         input logic cs);
        send(1'b0, a);
        check({tag, " errA"}, err, 0);
        send(1'b1, b);
        check({tag, " errB"}, err, 0);
        if (cs) begin
            seg_strobe = 1'b1;
            digit_sel  = 1'b1;
            seg_in     = 7'h3F;
        end
        @(negedge clk);
        seg_strobe = 1'b0;
        check({tag, " valid"}, valid, ev);
        check({tag, " err"}, err, ee);
        check({tag, " A"}, A_out, ea);
        check({tag, " B"}, B_out, eb);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst A", A_out, 0);
        check("rst B", B_out, 0);
        check("rst valid", valid, 0);
        check("rst err", err, 0);
        nRST = 1'b1;

        // two identical frames commit 9/0
        frame("f1", 7'h6F, 7'h3F, 0, 0, 4'h0, 4'h0, 0);
        frame("f2", 7'h6F, 7'h3F, 1, 0, 4'h9, 4'h0, 0);
        @(negedge clk);
        check("f2 pulse", valid, 0);
        // saturated: no re-pulse
        frame("f3", 7'h6F, 7'h3F, 0, 0, 4'h9, 4'h0, 0);

        // change of frame restarts stability
        frame("c1", 7'h06, 7'h3F, 0, 0, 4'h9, 4'h0, 0);
        frame("c2", 7'h06, 7'h3F, 1, 0, 4'h1, 4'h0, 0);

`ifdef HEX_DECODE_EN
        frame("h0", 7'h77, 7'h3F, 0, 0, 4'h1, 4'h0, 0);
        frame("h1", 7'h77, 7'h71, 0, 0, 4'h1, 4'h0, 0);
        frame("h2", 7'h77, 7'h71, 1, 0, 4'hA, 4'hF, 0);
`else
        frame("h0", 7'h77, 7'h3F, 0, 1, 4'h1, 4'h0, 0);
        frame("h1", 7'h77, 7'h71, 0, 1, 4'h1, 4'h0, 0);
        frame("h2", 7'h77, 7'h71, 0, 1, 4'h1, 4'h0, 0);
`endif
        @(negedge clk);
        check("h pulse", err, 0);

        // B strobe in SCAN_A: err, stays in SCAN_A
        send(1'b1, 7'h3F);
        check("oo err", err, 1);
        check("oo valid", valid, 0);
        @(negedge clk);
        check("oo pulse", err, 0);
        frame("s1", 7'h4F, 7'h5B, 0, 0, 4'h1, 4'h0, 0);
        frame("s2", 7'h4F, 7'h5B, 1, 0, 4'h3, 4'h2, 0);

        // strobe during COMMIT is ignored
        frame("m1", 7'h66, 7'h5B, 0, 0, 4'h3, 4'h2, 1);
        frame("m2", 7'h66, 7'h5B, 1, 0, 4'h4, 4'h2, 1);

        // A then B in SCAN_B resyncs with err
        send(1'b0, 7'h7F);
        send(1'b0, 7'h07);
        check("rs err", err, 1);
        send(1'b1, 7'h7D);
        check("rs errB", err, 0);
        @(negedge clk);
        check("rs valid", valid, 0);
        frame("rs2", 7'h07, 7'h7D, 1, 0, 4'h7, 4'h6, 0);

        // reset between A and B strobes
        send(1'b0, 7'h6F);
        #1 nRST = 1'b0;
        #1;
        check("mid rst A", A_out, 0);
        check("mid rst B", B_out, 0);
        #1 nRST = 1'b1;
        send(1'b1, 7'h3F);
        check("mid rst err", err, 1);

        // establish 6/7, then disable
        frame("e1", 7'h7D, 7'h07, 0, 0, 4'h0, 4'h0, 0);
        frame("e2", 7'h7D, 7'h07, 1, 0, 4'h6, 4'h7, 0);
        nEN = 1'b1;
        for (int i = 0; i < 3; i++) begin
            frame("dis", 7'h6F, 7'h3F, 0, 0, 4'h6, 4'h7, 0);
        end
        send(1'b1, 7'h3F);
        check("dis oo err", err, 0);
        nEN = 1'b0;
        // previous frame was invalidated while disabled
        frame("r1", 7'h7D, 7'h07, 0, 0, 4'h6, 4'h7, 0);
        frame("r2", 7'h6F, 7'h3F, 0, 0, 4'h6, 4'h7, 0);
        frame("r3", 7'h6F, 7'h3F, 1, 0, 4'h9, 4'h0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
